// File: rtl/vc_arbiter_pkg.sv
// Shared QoS datapath definitions: VC owner encoding, default word width,
// control-FSM state constants and small arithmetic helpers.
package vc_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 6;

    typedef enum logic {
        OWN_VC0 = 1'b0,
        OWN_VC1 = 1'b1
    } owner_e;

    // Control FSM states; the arbiter runs only in QOS_ACTIVE.
    typedef enum logic [1:0] {
        QOS_IDLE   = 2'd0,
        QOS_INIT   = 2'd1,
        QOS_ACTIVE = 2'd2,
        QOS_DRAIN  = 2'd3
    } qos_state_e;

    function automatic logic qos_is_active(input qos_state_e st);
        return (st == QOS_ACTIVE);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
        logic [3:0] res;
        if (cnt >= lim) begin
            res = lim;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vc_arbiter_grant_counter.sv
// Wrapping grant counter with synchronous active-low clear.
module grant_counter
    import vc_arbiter_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_r;

    // Count register; wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/vc_arbiter.sv
// Weighted two-way arbiter draining VC0/VC1 FIFOs into the Main FIFO.
// Pops are combinational so a grant and its push pipeline at 1 word/cycle.
module vc_arbiter
    import vc_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int VC0_WEIGHT = 4,
    parameter int VC1_WEIGHT = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active_in,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  mf_almost_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  mf_push,
    output logic [DATA_WIDTH-1:0] mf_data,
    output logic                  grant_vc1,
    output logic [CNT_WIDTH-1:0]  vc0_grants,
    output logic [CNT_WIDTH-1:0]  vc1_grants
);

    localparam logic [3:0] W0 = 4'(VC0_WEIGHT);
    localparam logic [3:0] W1 = 4'(VC1_WEIGHT);

    owner_e     owner_r;
    owner_e     owner_nxt_s;
    logic [3:0] burst_r;
    logic [3:0] burst_nxt_s;
    logic       push_r;
    logic       sel_r;
    logic       eligible_s;
    logic       own_empty_s;
    logic       oth_empty_s;
    logic [3:0] weight_s;
    logic       pop0_s;
    logic       pop1_s;

    assign eligible_s = active_in & ~mf_almost_full & reset;

    // Map owner-relative view (own/other FIFO, current weight).
    always_comb begin
        own_empty_s = vc0_empty;
        oth_empty_s = vc1_empty;
        weight_s    = W0;
        case (owner_r)
            OWN_VC0: begin
                own_empty_s = vc0_empty;
                oth_empty_s = vc1_empty;
                weight_s    = W0;
            end
            OWN_VC1: begin
                own_empty_s = vc1_empty;
                oth_empty_s = vc0_empty;
                weight_s    = W1;
            end
            default: begin
                own_empty_s = 1'b1;
                oth_empty_s = 1'b1;
                weight_s    = W0;
            end
        endcase
    end

    // Grant decision: stay with owner until its weight is spent, then switch.
    always_comb begin
        pop0_s      = 1'b0;
        pop1_s      = 1'b0;
        owner_nxt_s = owner_r;
        burst_nxt_s = burst_r;
        if (eligible_s) begin
            if (!own_empty_s && ((burst_r < weight_s) || oth_empty_s)) begin
                burst_nxt_s = sat_inc(burst_r, weight_s);
                if (owner_r == OWN_VC1) begin
                    pop1_s = 1'b1;
                end else begin
                    pop0_s = 1'b1;
                end
            end else if (!oth_empty_s) begin
                burst_nxt_s = 4'd1;
                if (owner_r == OWN_VC1) begin
                    owner_nxt_s = OWN_VC0;
                    pop0_s      = 1'b1;
                end else begin
                    owner_nxt_s = OWN_VC1;
                    pop1_s      = 1'b1;
                end
            end else begin
                owner_nxt_s = owner_r;
                burst_nxt_s = burst_r;
            end
        end else begin
            owner_nxt_s = owner_r;
            burst_nxt_s = burst_r;
        end
    end

    // Arbiter state and push pipeline; reset drops any pending push.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_r <= OWN_VC0;
            burst_r <= 4'd0;
            push_r  <= 1'b0;
            sel_r   <= 1'b0;
        end else begin
            owner_r <= owner_nxt_s;
            burst_r <= burst_nxt_s;
            push_r  <= pop0_s | pop1_s;
            sel_r   <= pop1_s;
        end
    end

    assign vc0_pop   = pop0_s;
    assign vc1_pop   = pop1_s;
    assign mf_push   = push_r;
    assign mf_data   = sel_r ? vc1_data : vc0_data;
    assign grant_vc1 = (owner_r == OWN_VC1);

    grant_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_vc0 (
        .clk   (clk),
        .clr_n (reset),
        .inc   (pop0_s),
        .count (vc0_grants)
    );

    grant_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_vc1 (
        .clk   (clk),
        .clr_n (reset),
        .inc   (pop1_s),
        .count (vc1_grants)
    );

endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: queue-based FIFO/arbitration model plus
// directed scenarios with hand-computed pins.
module tb_vc_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       active_in = 1'b0;
    logic       vc0_empty = 1'b1;
    logic       vc1_empty = 1'b1;
    logic [5:0] vc0_data = 6'd0;
    logic [5:0] vc1_data = 6'd0;
    logic       mf_almost_full = 1'b0;
    logic       vc0_pop;
    logic       vc1_pop;
    logic       mf_push;
    logic [5:0] mf_data;
    logic       grant_vc1;
    logic [7:0] vc0_grants;
    logic [7:0] vc1_grants;

    always #5 clk = ~clk;

    vc_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .active_in      (active_in),
        .vc0_empty      (vc0_empty),
        .vc1_empty      (vc1_empty),
        .vc0_data       (vc0_data),
        .vc1_data       (vc1_data),
        .mf_almost_full (mf_almost_full),
        .vc0_pop        (vc0_pop),
        .vc1_pop        (vc1_pop),
        .mf_push        (mf_push),
        .mf_data        (mf_data),
        .grant_vc1      (grant_vc1),
        .vc0_grants     (vc0_grants),
        .vc1_grants     (vc1_grants)
    );

    int errors = 0;
    int checks = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];

    // Model of arbitration outcome, in plain integers.
    int         m_owner = 0;
    int         m_burst = 0;
    int         m_cnt0 = 0;
    int         m_cnt1 = 0;
    bit         m_push = 1'b0;
    logic [5:0] m_word = 6'd0;
    int         pend = 0;
    logic [5:0] pend_word = 6'd0;
    bit         m_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, compare, advance the model.
    task automatic step(input bit a, input bit af, input bit rst);
        int w;
        int own_sz;
        int oth_sz;
        int exp_pop;
        @(negedge clk);
        if (pend == 1) vc0_data = pend_word;
        else if (pend == 2) vc1_data = pend_word;
        active_in      = a;
        mf_almost_full = af;
        reset          = rst;
        vc0_empty      = (q0.size() == 0);
        vc1_empty      = (q1.size() == 0);
        #1;
        if (m_valid) begin
            check("mf_push", int'(mf_push), int'(m_push));
            if (m_push) check("mf_data", int'(mf_data), int'(m_word));
            check("grant_vc1", int'(grant_vc1), m_owner);
            check("vc0_grants", int'(vc0_grants), m_cnt0);
            check("vc1_grants", int'(vc1_grants), m_cnt1);
        end
        w      = (m_owner == 0) ? 4 : 1;
        own_sz = (m_owner == 0) ? q0.size() : q1.size();
        oth_sz = (m_owner == 0) ? q1.size() : q0.size();
        exp_pop = 0;
        if (a && !af && rst) begin
            if (own_sz > 0 && (m_burst < w || oth_sz == 0)) begin
                exp_pop = m_owner + 1;
                m_burst = (m_burst + 1 > w) ? w : m_burst + 1;
            end else if (oth_sz > 0) begin
                m_owner = 1 - m_owner;
                exp_pop = m_owner + 1;
                m_burst = 1;
            end
        end
        check("vc0_pop", int'(vc0_pop), int'(exp_pop == 1));
        check("vc1_pop", int'(vc1_pop), int'(exp_pop == 2));
        pend = exp_pop;
        if (exp_pop == 1) pend_word = q0.pop_front();
        else if (exp_pop == 2) pend_word = q1.pop_front();
        if (rst) begin
            m_push = (exp_pop != 0);
            m_word = pend_word;
            if (exp_pop == 1) m_cnt0 = (m_cnt0 + 1) % 256;
            if (exp_pop == 2) m_cnt1 = (m_cnt1 + 1) % 256;
        end else begin
            m_owner = 0;
            m_burst = 0;
            m_cnt0  = 0;
            m_cnt1  = 0;
            m_push  = 1'b0;
            m_valid = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("rst_push", int'(mf_push), 0);
        check("rst_grant_vc1", int'(grant_vc1), 0);
        check("rst_vc0_grants", int'(vc0_grants), 0);
        check("rst_vc1_grants", int'(vc1_grants), 0);

        // Weighting 4:1 with both VCs loaded
        for (int i = 0; i < 10; i++) begin
            q0.push_back(6'(i));
            q1.push_back(6'(32 + i));
        end
        step(1'b1, 1'b0, 1'b1);
        check("w_first_vc0", int'(vc0_pop), 1);
        run(3);
        step(1'b1, 1'b0, 1'b1);
        check("w_fifth_vc1", int'(vc1_pop), 1);
        run(6);
        check("w_vc0_grants", int'(vc0_grants), 8);
        check("w_vc1_grants", int'(vc1_grants), 2);
        run(12);

        // Single channel saturation, then VC1 arrives
        for (int i = 0; i < 6; i++) q0.push_back(6'(10 + i));
        run(5);
        q1.push_back(6'd50);
        step(1'b1, 1'b0, 1'b1);
        check("sat_switch_vc1", int'(vc1_pop), 1);
        run(4);

        // Back-pressure mid-burst
        for (int i = 0; i < 8; i++) begin
            q0.push_back(6'(20 + i));
            q1.push_back(6'(40 + i));
        end
        run(2);
        step(1'b1, 1'b1, 1'b1);
        check("bp_inflight_push", int'(mf_push), 1);
        step(1'b1, 1'b1, 1'b1);
        check("bp_no_push", int'(mf_push), 0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("bp_resume_vc0", int'(vc0_pop), 1);
        step(1'b1, 1'b0, 1'b1);
        check("bp_held_burst_vc1", int'(vc1_pop), 1);
        run(18);

        // Freeze twice with both VCs non-empty
        for (int i = 0; i < 6; i++) begin
            q0.push_back(6'(60 - i));
            q1.push_back(6'(3 * i));
        end
        run(1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        run(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check("frz_no_pop", int'(vc0_pop | vc1_pop), 0);
        run(15);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) begin
            q0.push_back(6'(7 + i));
            q1.push_back(6'(17 + i));
        end
        run(1);
        step(1'b1, 1'b0, 1'b0);
        check("mr_pops_in_reset", int'(vc0_pop | vc1_pop), 0);
        step(1'b1, 1'b0, 1'b1);
        check("mr_push_dropped", int'(mf_push), 0);
        check("mr_vc0_grants", int'(vc0_grants), 0);
        check("mr_grant_vc1", int'(grant_vc1), 0);
        check("mr_restart_vc0", int'(vc0_pop), 1);
        run(12);

        // Counter wrap after 256 VC0 grants
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) q0.push_back(6'(i));
        run(256);
        check("wrap_255", int'(vc0_grants), 255);
        run(1);
        check("wrap_vc0_zero", int'(vc0_grants), 0);
        check("wrap_vc1_zero", int'(vc1_grants), 0);
        run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Weighted two-way arbiter that drains the VC0 and VC1 virtual-channel FIFOs into the Main FIFO of the PCIe QoS datapath. It issues pops to the VC FIFOs and pushes to the Main FIFO. It runs only while the control FSM reports ACTIVE and honours Main FIFO back-pressure. VC0 is the high-QoS channel and receives up to `VC0_WEIGHT` consecutive grants per VC1 grant.

## Interface
Parameters:
- `DATA_WIDTH`, 6: width of a FIFO word.
- `VC0_WEIGHT`, 4: maximum consecutive VC0 grants while VC1 is non-empty (1..15).
- `VC1_WEIGHT`, 1: maximum consecutive VC1 grants while VC0 is non-empty (1..15).
- `CNT_WIDTH`, 8: width of the per-VC grant counters.

Ports (clock and reset: one clock `clk`; `reset` is synchronous and active-low):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `active_in`  in  1  FSM ACTIVE indication; 0 freezes arbitration.
- `vc0_empty`, `vc1_empty`  in  1  VC FIFO empty flags.
- `vc0_data`, `vc1_data`  in  `DATA_WIDTH`  VC FIFO read data, valid 1 cycle after pop.
- `mf_almost_full`  in  1  Main FIFO almost-full flag (guarantees ≥1 free slot).
- `vc0_pop`, `vc1_pop`  out  1  pop strobes (combinational).
- `mf_push`  out  1  Main FIFO push (registered).
- `mf_data`  out  `DATA_WIDTH`  word to Main FIFO.
- `grant_vc1`  out  1  owner state: 0 = VC0, 1 = VC1.
- `vc0_grants`, `vc1_grants`  out  `CNT_WIDTH`  wrapping grant counters.

## Operation
- State: `OWN_VC0` / `OWN_VC1` plus a 4-bit `burst_cnt`.
- Eligibility: a grant may issue only when `active_in`=1, `mf_almost_full`=0 and `reset`=1. Otherwise both pops are 0.
- Grant decision each eligible cycle, with `W` = weight of the current owner:
  - Owner non-empty and (`burst_cnt` < `W`, or other VC empty): pop the owner. `burst_cnt` = min(`burst_cnt`+1, `W`).
  - Otherwise, if the other VC is non-empty: switch owner, pop the other VC, `burst_cnt`=1.
  - Both empty: no pop; state and `burst_cnt` are held.
- Saturation: `burst_cnt` saturates at `W`. When the other VC becomes non-empty, the switch happens on the next eligible grant.
- Mutual exclusion: at most one pop per cycle. Pops are never issued to an empty FIFO.
- Counters: each pop increments the matching `vcN_grants`, modulo 2^`CNT_WIDTH` (wraps 255→0).
- Freeze: `active_in` falling or `mf_almost_full` rising mid-burst holds the owner and `burst_cnt`. An in-flight push still completes.

## Timing
- Pop in cycle N → `mf_push`=1 in cycle N+1.
- `mf_data` in cycle N+1 is `vc1_data` if `vc1_pop` was issued in cycle N, else `vc0_data`. It is a combinational mux driven by a registered select.
- Sustained throughput is 1 word/cycle. The arbitration decision itself adds no bubble.
- `mf_almost_full` is sampled combinationally. The Main FIFO threshold must leave ≥1 slot for the in-flight word.
- Reset values (cycle after a `reset`=0 edge): `mf_push`=0, `grant_vc1`=0 (`OWN_VC0`), `burst_cnt`=0, both grant counters 0, select=0.
- While `reset`=0, pops are 0.
- Reset mid-operation drops the pending push: no `mf_push` the cycle after the reset edge.

## Structure
- Shared QoS package holds:
  - owner state encoding (`OWN_VC0`=0, `OWN_VC1`=1);
  - `DATA_WIDTH` default of 6;
  - FSM state constants used to derive `active_in`.
- One natural sub-module: `grant_counter`, a `CNT_WIDTH` wrapping counter with synchronous active-low clear. It is instantiated twice.

## Test plan
- Weighting: both VCs hold 10 words, `active_in`=1, weights 4/1 → pop pattern VC0×4, VC1×1, repeating. `mf_push` follows each pop by 1 cycle with matching data. `vc0_grants`=8 after 10 pushes.
- Single channel: VC1 empty, VC0 holds 6 words → 6 consecutive VC0 pops and `burst_cnt` saturates at 4. VC1 gets one word mid-run → the next grant goes to VC1.
- Back-pressure: `mf_almost_full`=1 for 3 cycles mid-burst → pops are 0 for those 3 cycles. The in-flight word is pushed once. The burst resumes from the held `burst_cnt`.
- Freeze: `active_in` 1→0 for 5 cycles, then 1→0 again with both VCs non-empty → no pops while 0. Owner is unchanged on resume.
- Reset mid-operation: `reset`=0 on the cycle after a pop → no `mf_push` follows. Counters are 0 and `grant_vc1`=0. After `reset`=1, arbitration restarts with VC0.
- Counter wrap: 256 VC0 grants → `vc0_grants` returns to 0; `vc1_grants` is unaffected.
